// File: rtl/div_clk_monitor_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
// Divider benches import the defaults so their targets match the monitor.
package div_clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_EXP_PERIOD = 200;
    localparam int unsigned DEF_TOL        = 2;
    localparam int unsigned DEF_LOCK_N     = 4;
    localparam int unsigned DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/div_clk_monitor_sync_edge_det.sv
// Brings an asynchronous slow clock into the clk domain and flags its edges.
// Edge strobes are combinational on the flops, so they carry the _c suffix.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [1:0] sync;
    logic       dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[0], d};
            dly  <= sync[1];
        end
    end

    assign rise_c = sync[1] & ~dly;
    assign fall_c = ~sync[1] & dly;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles,
// tracks lock against a target period and flags a stalled input.
module div_clk_monitor
    import div_clk_monitor_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned LOCK_N     = DEF_LOCK_N,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout_err
);

    localparam int unsigned EXT_W   = CNT_W + 1;
    localparam int unsigned MATCH_W = $clog2(LOCK_N + 2);

    logic               rise_c;
    logic               fall_c;
    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [MATCH_W-1:0] match;
    logic [EXT_W-1:0]   meas_c;
    logic [MATCH_W-1:0] match_inc_c;
    logic               in_tol_c;
    logic               lock_hit_c;
    logic               stall_c;

    sync_edge_det u_sync (
        .clk    (clk_in),
        .rst_n  (rst),
        .d      (slow_in),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Measurement is the strobe-to-strobe distance; the extra bit keeps the window test wrap-free.
    always_comb begin
        meas_c      = EXT_W'(cnt) + EXT_W'(1);
        in_tol_c    = (meas_c >= EXT_W'(EXP_PERIOD - TOL)) &&
                      (meas_c <= EXT_W'(EXP_PERIOD + TOL));
        match_inc_c = match + MATCH_W'(1);
        lock_hit_c  = (match_inc_c >= MATCH_W'(LOCK_N));
        stall_c     = (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            match       <= '0;
            period_out  <= '0;
            high_out    <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (fall_c && (state != IDLE)) begin
                high_out <= meas_c[CNT_W-1:0];
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise_c) begin
                        state <= MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    // A rise on the last counted cycle wins over the stall check.
                    if (rise_c) begin
                        cnt         <= '0;
                        period_out  <= meas_c[CNT_W-1:0];
                        meas_valid  <= 1'b1;
                        timeout_err <= 1'b0;
                        if (in_tol_c) begin
                            if (lock_hit_c) begin
                                match  <= MATCH_W'(LOCK_N);
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                match <= match_inc_c;
                            end
                        end else begin
                            match  <= '0;
                            state  <= MEASURE;
                            locked <= 1'b0;
                        end
                    end else if (stall_c) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        match       <= '0;
                        locked      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: an edge-event model predicts every output
// each cycle, and literal expectations pin the headline scenarios.
module tb_div_clk_monitor;

    localparam int unsigned CNT_W   = 16;
    localparam int          EXP     = 200;
    localparam int          TOL     = 2;
    localparam int          LOCK_N  = 4;
    localparam int          TIMEOUT = 1024;

    logic             clk_in  = 1'b0;
    logic             rst     = 1'b0;
    logic             slow_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             locked;
    logic             timeout_err;

    div_clk_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .LOCK_N     (LOCK_N),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .slow_in     (slow_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Event-level model: a level change sampled at edge m is acted on at edge m+2;
    // measurements are edge-index differences between those events.
    int       n_edge = 0;
    bit [3:0] h = 4'b0;
    bit       m_armed = 0, m_locked = 0, m_terr = 0, m_mv = 0;
    int       m_last = 0, m_match = 0, m_period = 0, m_high = 0;
    bit       ev_rise, ev_fall;
    int       p;

    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            h = 4'b0; m_armed = 0; m_locked = 0; m_terr = 0; m_mv = 0;
            m_last = 0; m_match = 0; m_period = 0; m_high = 0;
        end else begin
            n_edge++;
            h = {h[2:0], slow_in};
            ev_rise = h[2] & ~h[3];
            ev_fall = ~h[2] & h[3];
            m_mv = 0;
            if (ev_fall && m_armed) m_high = n_edge - m_last;
            if (ev_rise) begin
                if (m_armed) begin
                    p = n_edge - m_last;
                    m_period = p;
                    m_mv = 1;
                    m_terr = 0;
                    if (p >= EXP - TOL && p <= EXP + TOL) begin
                        if (m_match < LOCK_N) m_match++;
                    end else begin
                        m_match = 0;
                    end
                    m_locked = (m_match == LOCK_N);
                end
                m_armed = 1;
                m_last = n_edge;
            end else if (m_armed && (n_edge - m_last == TIMEOUT)) begin
                m_armed = 0; m_terr = 1; m_match = 0; m_locked = 0;
            end
        end
    end

    // Per-cycle comparison plus bookkeeping for the literal checks.
    bit cmp_en = 0;
    bit prev_mv = 0, prev_locked = 0;
    int mv_total = 0, lock_mv = -1, drop_period = 0, drop_mv = 0;

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("period_out", period_out, m_period);
            check("high_out", high_out, m_high);
            check("meas_valid", meas_valid, m_mv);
            check("locked", locked, m_locked);
            check("timeout_err", timeout_err, m_terr);
            if (meas_valid) check("mv_width", prev_mv, 0);
        end
        if (meas_valid) mv_total++;
        if (locked && !prev_locked && lock_mv < 0) lock_mv = mv_total;
        if (!locked && prev_locked && rst) begin
            drop_period = period_out;
            drop_mv = meas_valid;
        end
        prev_mv = meas_valid;
        prev_locked = locked;
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk_in);
    endtask

    task automatic sq(input int hi, input int lo);
        slow_in = 1'b1;
        cyc(hi);
        slow_in = 1'b0;
        cyc(lo);
    endtask

    int mv0, n, waited;

    initial begin
        cyc(3);
        rst = 1'b1;
        cyc(1);
        cmp_en = 1;
        check("reset_period", period_out, 0);
        check("reset_locked", locked, 0);
        cyc(4);

        // Nominal square wave: five measurements, lock on the fourth.
        mv0 = mv_total;
        repeat (6) sq(100, 100);
        check("t1_mv_count", mv_total - mv0, 5);
        check("t1_lock_at_mv", lock_mv - mv0, 4);
        check("t1_period", period_out, 200);
        check("t1_high", high_out, 100);
        check("t1_locked", locked, 1);

        // One long period drops lock together with its strobe; four good ones relock.
        sq(100, 105);
        repeat (5) sq(100, 100);
        check("t2_drop_period", drop_period, 205);
        check("t2_drop_with_mv", drop_mv, 1);
        check("t2_relocked", locked, 1);

        // Stall: timeout 1024 cycles after the last rise is acted on.
        slow_in = 1'b1;
        waited = 0;
        while (!meas_valid && waited < 20) begin cyc(1); waited++; end
        check("t3_rise_seen", meas_valid, 1);
        n = 0;
        while (!timeout_err && n < 2000) begin
            cyc(1);
            n++;
            if (n == 97) slow_in = 1'b0;
        end
        check("t3_timeout_delay", n, 1024);
        check("t3_locked", locked, 0);
        check("t3_period_held", period_out, 200);
        mv0 = mv_total;
        repeat (2) sq(100, 100);
        check("t3_rearm_mv_count", mv_total - mv0, 1);
        check("t3_terr_cleared", timeout_err, 0);
        check("t3_period", period_out, 200);

        // 198/202 alternation stays in window; a 197 drops out.
        repeat (3) begin sq(99, 99); sq(101, 101); end
        check("t4_locked", locked, 1);
        sq(98, 99);
        sq(100, 100);
        check("t4_period_197", period_out, 197);
        check("t4_unlocked", locked, 0);

        // Asynchronous reset mid-period while locked.
        repeat (5) sq(100, 100);
        check("t5_locked_before", locked, 1);
        slow_in = 1'b1;
        cyc(50);
        #2;
        rst = 1'b0;
        slow_in = 1'b0;
        #1;
        check("t5_rst_period", period_out, 0);
        check("t5_rst_high", high_out, 0);
        check("t5_rst_mv", meas_valid, 0);
        check("t5_rst_locked", locked, 0);
        check("t5_rst_terr", timeout_err, 0);
        cyc(3);
        rst = 1'b1;
        mv0 = mv_total;
        repeat (2) sq(100, 100);
        check("t5_mv_count", mv_total - mv0, 1);
        check("t5_period", period_out, 200);

        // Edges off the clock grid with drifting phase.
        @(negedge clk_in);
        #1;
        repeat (6) begin
            slow_in = 1'b1;
            #1003;
            slow_in = 1'b0;
            #1000;
        end
        cyc(5);
        check_range("t6_period", period_out, EXP - 1, EXP + 1);
        check_range("t6_high", high_out, 99, 101);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
